// File: rtl/day3_if.sv
// Bundle for the monitored level and the two edge-pulse outputs of day3.
// master drives the level and observes pulses; slave is the detector side.
interface day3_if;
   logic a;
   logic rise;
   logic fall;

   modport master (
      output a,
      input  rise,
      input  fall
   );

   modport slave (
      input  a,
      output rise,
      output fall
   );
endinterface

// File: rtl/day3.sv
// Edge detector: combinational rising/falling pulses from a level vs. its registered history.
// Define DAY3_SYNC_EN to insert a two-flop synchronizer in front of the detector.
module day3 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic a_i,
   output logic rising_edge_o,
   output logic falling_edge_o
);

   logic a_s;
   logic a_q;
   logic a_d;

`ifdef DAY3_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
      end else begin
         sync1_q <= a_i;
         sync2_q <= sync1_q;
      end
   end

   assign a_s = sync2_q;
`else
   assign a_s = a_i;
`endif

   assign a_d = a_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= RESET_VAL;
      end else begin
         a_q <= a_d;
      end
   end

   // Gating by reset drops any pending pulse the instant reset asserts.
   assign rising_edge_o  = reset &  a_s & ~a_q;
   assign falling_edge_o = reset & ~a_s &  a_q;

endmodule

// File: tb/tb_day3.sv
// Directed bench for day3 (default build): expected pulses are queued when a_i is driven
// and popped when the outputs are sampled mid-cycle.
module tb_day3;
   localparam logic RV = 1'b0;

   logic clk;
   logic reset;
   logic [1:0] exp_q[$];
   logic prev_m;
   int compared;
   int mismatched;

   day3_if u_if ();

   day3 #(
      .RESET_VAL(RV)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .a_i           (u_if.a),
      .rising_edge_o (u_if.rise),
      .falling_edge_o(u_if.fall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Push the outputs expected after driving level a with the current model history.
   task automatic drive(input logic a);
      u_if.a = a;
      if (reset) exp_q.push_back({a & ~prev_m, ~a & prev_m});
      else       exp_q.push_back(2'b00);
   endtask

   task automatic check(input string tag);
      logic [1:0] got;
      logic [1:0] exp;
      got = {u_if.rise, u_if.fall};
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $error("FAIL %s: observed %b but scoreboard empty (expected entry)", tag, got);
      end else begin
         exp = exp_q.pop_front();
         assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed rise/fall=%b expected %b", tag, got, exp);
         end
      end
   endtask

   // One cycle: model captures the level at the edge, then a_i changes just after it.
   task automatic step(input logic a, input string tag);
      @(posedge clk);
      prev_m = reset ? u_if.a : RV;
      #1;
      drive(a);
      #3;
      check(tag);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      u_if.a     = 1'b1;
      prev_m     = RV;

      step(1'b1, "rst_hold0");
      step(1'b1, "rst_hold1");
      step(1'b1, "rst_hold2");

      // Release with a_i=1 differing from RESET_VAL: rise pending until first edge.
      @(negedge clk);
      reset  = 1'b1;
      prev_m = RV;
      drive(1'b1);
      #1;
      check("post_rst_rise");

      step(1'b1, "rise_done");
      step(1'b1, "stable_hi");
      step(1'b0, "fall");
      step(1'b0, "fall_done");
      step(1'b1, "rise");
      step(1'b1, "rise_hold1");
      step(1'b1, "rise_hold2");

      step(1'b0, "tog_fall0");
      step(1'b1, "tog_rise0");
      step(1'b0, "tog_fall1");
      step(1'b1, "tog_rise1");
      step(1'b1, "tog_done");

      // Glitch that returns before the next edge leaves no registered change.
      @(posedge clk);
      prev_m = u_if.a;
      #1;
      u_if.a = 1'b0;
      #1;
      drive(1'b1);
      #1;
      check("glitch_back");
      step(1'b1, "glitch_after");

      // Reset mid-pulse kills the output with no clock edge.
      step(1'b0, "pre_fall");
      step(1'b1, "mid_rise");
      #1;
      reset  = 1'b0;
      prev_m = RV;
      exp_q.push_back(2'b00);
      #1;
      check("rst_kill");
      step(1'b1, "in_rst");

      @(negedge clk);
      reset  = 1'b1;
      prev_m = RV;
      drive(1'b1);
      #1;
      check("rel_rise");
      step(1'b1, "rel_done");
      step(1'b0, "final_fall");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
